// File: rtl/req_hold_limiter_pkg.sv
// Shared arbitration definitions: requester count, channel FSM states and default hold limits.
package arb_pkg;

  localparam int NUM_REQ      = 3;
  localparam int DEF_MAX_HOLD = 8;
  localparam int DEF_COOLDOWN = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_COOL
  } chan_state_t;

endpackage

// File: rtl/req_hold_limiter_if.sv
// Request/grant bundle between requesters, the hold limiter and the arbiter.
// Carries viol_count only when REQ_HOLD_STATS_EN is defined.
interface req_hold_limiter_if;
  import arb_pkg::*;

  logic [NUM_REQ:1] r_in;
  logic [NUM_REQ:1] g;
  logic [NUM_REQ:1] r_out;
  logic [NUM_REQ:1] blocked;
  logic [NUM_REQ:1] viol;
`ifdef REQ_HOLD_STATS_EN
  logic [8*NUM_REQ-1:0] viol_count;

  modport master (output r_in, output g, input r_out, input blocked, input viol, input viol_count);
  modport slave  (input r_in, input g, output r_out, output blocked, output viol, output viol_count);
`else
  modport master (output r_in, output g, input r_out, input blocked, input viol);
  modport slave  (input r_in, input g, output r_out, output blocked, output viol);
`endif

endinterface

// File: rtl/req_hold_limiter_chan.sv
// One channel of the hold limiter: IDLE/HELD/COOL FSM with hold and cooldown counters.
// With REQ_HOLD_STATS_EN defined, also keeps a saturating 8-bit violation counter.
module req_hold_chan
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int COOLDOWN = DEF_COOLDOWN,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       r_in,
  input  logic       g,
  output logic       r_out,
  output logic       blocked,
  output logic       viol
`ifdef REQ_HOLD_STATS_EN
  ,
  output logic [7:0] viol_count
`endif
);

  chan_state_t      state;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] cc;

  // g is not looked at in COOL: the arbiter releases one cycle after r_out drops
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
      hc    <= '0;
      cc    <= '0;
      viol  <= 1'b0;
    end else begin
      viol <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (g) begin
            state <= ST_HELD;
            hc    <= CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!g) begin
            state <= ST_IDLE;
            hc    <= '0;
          end else if (hc == CNT_W'(MAX_HOLD)) begin
            state <= ST_COOL;
            cc    <= CNT_W'(COOLDOWN);
            viol  <= 1'b1;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        ST_COOL: begin
          if (cc == CNT_W'(1)) begin
            state <= ST_IDLE;
            hc    <= '0;
          end else begin
            cc <= cc - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign blocked = (state == ST_COOL);
  assign r_out   = blocked ? 1'b0 : r_in;

`ifdef REQ_HOLD_STATS_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      viol_count <= '0;
    end else if (viol && (viol_count != 8'hFF)) begin
      viol_count <= viol_count + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/req_hold_limiter.sv
// Request conditioner in front of the fixed-priority arbiter: masks a channel that holds its grant too long.
// Define REQ_HOLD_STATS_EN to add per-channel saturating violation counters (viol_count).
module req_hold_limiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int COOLDOWN = DEF_COOLDOWN,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         areset,
  req_hold_limiter_if.slave bus
);

  for (genvar i = 1; i <= NUM_REQ; i++) begin : g_chan
    req_hold_chan #(
      .MAX_HOLD (MAX_HOLD),
      .COOLDOWN (COOLDOWN),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk        (clk),
      .areset     (areset),
      .r_in       (bus.r_in[i]),
      .g          (bus.g[i]),
      .r_out      (bus.r_out[i]),
      .blocked    (bus.blocked[i]),
      .viol       (bus.viol[i])
`ifdef REQ_HOLD_STATS_EN
      ,
      .viol_count (bus.viol_count[8*(i-1) +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_req_hold_limiter.sv
// Directed bench for req_hold_limiter (MAX_HOLD=8, COOLDOWN=4); grants are driven as the arbiter would.
// Stats check runs only when REQ_HOLD_STATS_EN is defined.
module tb_req_hold_limiter;

  logic clk;
  logic areset;
  int   tests_run;
  int   tests_failed;

  req_hold_limiter_if bus ();

  req_hold_limiter #(
    .MAX_HOLD (8),
    .COOLDOWN (4),
    .CNT_W    (4)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:1] r_in;
    logic [3:1] g;
    logic [3:1] r_out;
    logic [3:1] blocked;
    logic [3:1] viol;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [3:1] r_in, input logic [3:1] g,
                        input logic [3:1] r_out, input logic [3:1] blocked,
                        input logic [3:1] viol);
    vec_t v;
    v.r_in    = r_in;
    v.g       = g;
    v.r_out   = r_out;
    v.blocked = blocked;
    v.viol    = viol;
    vecs.push_back(v);
  endtask

  // Inputs change mid-cycle; outputs are sampled 1 ns after the following rising edge
  task automatic applyStimulus(input logic [3:1] r_in, input logic [3:1] g);
    @(negedge clk);
    bus.r_in = r_in;
    bus.g    = g;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:1] exp_r_out,
                             input logic [3:1] exp_blocked, input logic [3:1] exp_viol);
    tests_run++;
    if ({bus.r_out, bus.blocked, bus.viol} !== {exp_r_out, exp_blocked, exp_viol}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got r_out=%b blocked=%b viol=%b, expected r_out=%b blocked=%b viol=%b",
               name, bus.r_out, bus.blocked, bus.viol, exp_r_out, exp_blocked, exp_viol);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    areset       = 1'b1;
    bus.r_in     = 3'b101;
    bus.g        = 3'b000;

    // Reset state: everything IDLE, r_out passes r_in through
    #1;
    checkOutput("reset_state", 3'b101, 3'b000, 3'b000);
`ifdef REQ_HOLD_STATS_EN
    tests_run++;
    if (bus.viol_count !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_viol_count: got %h, expected %h", bus.viol_count, 24'd0);
    end
`endif
    @(negedge clk);
    areset = 1'b0;

    // Normal hold, 5 grant cycles then release
    addVec(3'b001, 3'b000, 3'b001, 3'b000, 3'b000);
    for (int k = 0; k < 5; k++) addVec(3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    addVec(3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    addVec(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    // Hold violation on channel 1 with channel 2 waiting
    addVec(3'b011, 3'b000, 3'b011, 3'b000, 3'b000);
    for (int k = 0; k < 8; k++) addVec(3'b011, 3'b001, 3'b011, 3'b000, 3'b000);
    addVec(3'b011, 3'b001, 3'b010, 3'b001, 3'b001);
    addVec(3'b011, 3'b001, 3'b010, 3'b001, 3'b000);
    addVec(3'b011, 3'b010, 3'b010, 3'b001, 3'b000);
    addVec(3'b011, 3'b010, 3'b010, 3'b001, 3'b000);
    addVec(3'b011, 3'b010, 3'b011, 3'b000, 3'b000);
    addVec(3'b011, 3'b010, 3'b011, 3'b000, 3'b000);
    addVec(3'b001, 3'b010, 3'b001, 3'b000, 3'b000);
    addVec(3'b001, 3'b000, 3'b001, 3'b000, 3'b000);
    addVec(3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    // Regranted channel 1 releases right at the 8th granted cycle
    for (int k = 0; k < 7; k++) addVec(3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    addVec(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    addVec(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r_in, vecs[i].g);
      checkOutput($sformatf("vec[%0d]", i), vecs[i].r_out, vecs[i].blocked, vecs[i].viol);
    end

    // Channel 3 violation, then reset on the second cooldown cycle
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(3'b100, 3'b100);
      if (k < 9) checkOutput($sformatf("ch3_hold[%0d]", k), 3'b100, 3'b000, 3'b000);
      else       checkOutput("ch3_enter_cool", 3'b000, 3'b100, 3'b100);
    end
    applyStimulus(3'b100, 3'b100);
    checkOutput("ch3_cool2", 3'b000, 3'b100, 3'b000);
    @(negedge clk);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("reset_mid_cool", 3'b100, 3'b000, 3'b000);
    bus.g = 3'b000;
    @(negedge clk);
    areset = 1'b0;
    // Re-entry starts at hc=1: the 9th consecutive grant is the first violation
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(3'b100, 3'b100);
      if (k < 9) checkOutput($sformatf("ch3_rehold[%0d]", k), 3'b100, 3'b000, 3'b000);
      else       checkOutput("ch3_reviol", 3'b000, 3'b100, 3'b100);
    end

`ifdef REQ_HOLD_STATS_EN
    @(negedge clk);
    areset = 1'b1;
    bus.g  = 3'b000;
    @(negedge clk);
    areset = 1'b0;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 9; k++) applyStimulus(3'b100, 3'b100);
      for (int k = 0; k < 4; k++) applyStimulus(3'b100, 3'b000);
    end
    tests_run++;
    if (bus.viol_count !== {8'd255, 8'd0, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL stats_saturate: got %h, expected %h", bus.viol_count, {8'd255, 8'd0, 8'd0});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
